// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the external SRAM.
// The arbiter takes the slave view; the CPU/SRAM side takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              if_ce_i;
    logic [31:0]       if_addr_i;
    logic [31:0]       if_data_o;
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_data_i;
    logic [3:0]        mem_sel_i;
    logic [31:0]       mem_data_o;
    logic              stallreq_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;
    logic [3:0]        sram_be_n_o;

    modport slave (
        input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i,
               mem_sel_i, sram_rdata_i,
        output if_data_o, mem_data_o, stallreq_o, sram_addr_o, sram_wdata_o,
               sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

    modport master (
        output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_data_i,
               mem_sel_i, sram_rdata_i,
        input  if_data_o, mem_data_o, stallreq_o, sram_addr_o, sram_wdata_o,
               sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported SRAM arbiter: data port wins over instruction fetch, each
// access lasts WAIT_CYCLES+1 cycles, pipeline stalled until all requests served.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_if_done;
    logic        r_mem_done;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_data;

    logic              w_mem_pend;
    logic              w_if_pend;
    logic              w_stall;
    logic              w_last;
    logic [ADDR_W-1:0] w_sram_addr;
    logic [31:0]       w_sram_wdata;
    logic              w_sram_ce_n;
    logic              w_sram_oe_n;
    logic              w_sram_we_n;
    logic [3:0]        w_sram_be_n;
    logic              w_unused_addr;

    assign w_mem_pend = bus.mem_ce_i & ~r_mem_done;
    assign w_if_pend  = bus.if_ce_i & ~r_if_done;
    assign w_stall    = rst & (w_mem_pend | w_if_pend);
    assign w_last     = (r_cnt == WAIT_CNT);

    // Byte offset and bits above the SRAM word range are not decoded.
    assign w_unused_addr = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0],
                             bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_data  <= 32'd0;
            r_mem_data <= 32'd0;
        end else begin
            // The edge with no stall is the one where the pipeline advances.
            if (!w_stall) begin
                r_if_done  <= 1'b0;
                r_mem_done <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_mem_pend) begin
                        r_state <= S_DATA;
                        r_cnt   <= 4'd0;
                    end else if (w_if_pend) begin
                        r_state <= S_INST;
                        r_cnt   <= 4'd0;
                    end
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        if (!bus.mem_we_i) begin
                            r_mem_data <= bus.sram_rdata_i;
                        end
                        r_mem_done <= 1'b1;
                        r_cnt      <= 4'd0;
                        r_state    <= w_if_pend ? S_INST : S_IDLE;
                    end
                end
                S_INST: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_if_data <= bus.sram_rdata_i;
                        r_if_done <= 1'b1;
                        r_cnt     <= 4'd0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_sram_addr  = '0;
        w_sram_wdata = 32'd0;
        w_sram_ce_n  = 1'b1;
        w_sram_oe_n  = 1'b1;
        w_sram_we_n  = 1'b1;
        w_sram_be_n  = 4'hF;
        case (r_state)
            S_DATA: begin
                w_sram_addr = bus.mem_addr_i[ADDR_W+1:2];
                w_sram_ce_n = 1'b0;
                w_sram_be_n = ~bus.mem_sel_i;
                if (bus.mem_we_i) begin
                    w_sram_we_n  = 1'b0;
                    w_sram_wdata = bus.mem_data_i;
                end else begin
                    w_sram_oe_n = 1'b0;
                end
            end
            S_INST: begin
                w_sram_addr = bus.if_addr_i[ADDR_W+1:2];
                w_sram_ce_n = 1'b0;
                w_sram_oe_n = 1'b0;
                w_sram_be_n = 4'h0;
            end
            default: ;
        endcase
    end

    assign bus.stallreq_o   = w_stall;
    assign bus.if_data_o    = r_if_data;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.sram_addr_o  = w_sram_addr;
    assign bus.sram_wdata_o = w_sram_wdata;
    assign bus.sram_ce_n_o  = w_sram_ce_n;
    assign bus.sram_oe_n_o  = w_sram_oe_n;
    assign bus.sram_we_n_o  = w_sram_we_n;
    assign bus.sram_be_n_o  = w_sram_be_n;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: WAIT_CYCLES=1 instance for the main scenarios, WAIT_CYCLES=0 for back-to-back fetches.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(20)) bus1 ();
    mem_arbiter_if #(.ADDR_W(20)) bus0 ();

    mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(20)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // SRAM models: asynchronous read, write activity captured for checking.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem0 [0:255];
    logic [31:0] wr_word1 = 32'd0;
    int          wr_count1 = 0;
    logic [31:0] wr_mask1;
    wire         tb_unused = ^{bus1.sram_addr_o[19:8], bus0.sram_addr_o[19:8],
                               bus0.sram_wdata_o, bus0.sram_we_n_o, bus0.sram_be_n_o,
                               bus0.mem_data_o};

    assign bus1.sram_rdata_i = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o) ? mem1[bus1.sram_addr_o[7:0]] : 32'd0;
    assign bus0.sram_rdata_i = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o) ? mem0[bus0.sram_addr_o[7:0]] : 32'd0;
    assign wr_mask1 = {{8{bus1.sram_be_n_o[3]}}, {8{bus1.sram_be_n_o[2]}},
                       {8{bus1.sram_be_n_o[1]}}, {8{bus1.sram_be_n_o[0]}}};

    always @(posedge clk) begin
        if (!bus1.sram_ce_n_o && !bus1.sram_we_n_o) begin
            wr_word1  <= (mem1[bus1.sram_addr_o[7:0]] & wr_mask1) | (bus1.sram_wdata_o & ~wr_mask1);
            wr_count1 <= wr_count1 + 1;
        end
    end

    // {stall, ce_n, oe_n, we_n, be_n}
    wire [7:0] ctl1 = {bus1.stallreq_o, bus1.sram_ce_n_o, bus1.sram_oe_n_o, bus1.sram_we_n_o, bus1.sram_be_n_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus1.if_ce_i = 1'b1; bus1.if_addr_i = 32'd0;
        bus1.mem_ce_i = 1'b0; bus1.mem_we_i = 1'b0; bus1.mem_addr_i = 32'd0;
        bus1.mem_data_i = 32'd0; bus1.mem_sel_i = 4'h0;
        bus0.if_ce_i = 1'b0; bus0.if_addr_i = 32'd0;
        bus0.mem_ce_i = 1'b0; bus0.mem_we_i = 1'b0; bus0.mem_addr_i = 32'd0;
        bus0.mem_data_i = 32'd0; bus0.mem_sel_i = 4'h0;
        tick(); tick();
        checks++; if (ctl1 !== 8'h7F) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl1, 8'h7F); end
        checks++; if (bus1.sram_addr_o !== 20'd0 || bus1.sram_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_bus addr %h wdata %h exp 0 0", bus1.sram_addr_o, bus1.sram_wdata_o); end
        checks++; if (bus1.if_data_o !== 32'd0 || bus1.mem_data_o !== 32'd0) begin errors++; $display("FAIL reset_data if %h mem %h exp 0 0", bus1.if_data_o, bus1.mem_data_o); end
        rst = 1'b1;
        #1;
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL reset_release got %b exp %b", ctl1, 8'hFF); end
        $display("reset: ctl %b after release", ctl1);
        bus1.if_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        mem1[4] = 32'h3401_0020;
        bus1.if_addr_i = 32'h0000_0010; bus1.if_ce_i = 1'b1;
        #1;
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL fetch_c0 got %b exp %b", ctl1, 8'hFF); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (ctl1 !== 8'h90 || bus1.sram_addr_o !== 20'd4) begin errors++; $display("FAIL fetch_c%0d ctl %b addr %h exp %b 4", c, ctl1, bus1.sram_addr_o, 8'h90); end
        end
        tick();
        checks++; if (ctl1 !== 8'h7F || bus1.if_data_o !== 32'h3401_0020) begin errors++; $display("FAIL fetch_done ctl %b data %h exp %b 34010020", ctl1, bus1.if_data_o, 8'h7F); end
        tick();
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL fetch_doneclr got %b exp %b", ctl1, 8'hFF); end
        $display("fetch: addr 0x10 data %h", bus1.if_data_o);
        bus1.if_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_load_fetch();
        mem1[8'h40] = 32'hDEAD_BEEF; mem1[5] = 32'h1234_5678;
        bus1.mem_ce_i = 1'b1; bus1.mem_we_i = 1'b0; bus1.mem_addr_i = 32'h100; bus1.mem_sel_i = 4'hF;
        bus1.if_ce_i = 1'b1; bus1.if_addr_i = 32'h14;
        #1;
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL lf_c0 got %b exp %b", ctl1, 8'hFF); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++; if (ctl1 !== 8'h90 || bus1.sram_addr_o !== ((c <= 2) ? 20'h40 : 20'h5)) begin errors++; $display("FAIL lf_c%0d ctl %b addr %h exp %b %h", c, ctl1, bus1.sram_addr_o, 8'h90, (c <= 2) ? 20'h40 : 20'h5); end
        end
        tick();
        checks++; if (ctl1 !== 8'h7F) begin errors++; $display("FAIL lf_end got %b exp %b", ctl1, 8'h7F); end
        checks++; if (bus1.mem_data_o !== 32'hDEAD_BEEF || bus1.if_data_o !== 32'h1234_5678) begin errors++; $display("FAIL lf_data mem %h if %h exp deadbeef 12345678", bus1.mem_data_o, bus1.if_data_o); end
        $display("load+fetch: mem %h if %h", bus1.mem_data_o, bus1.if_data_o);
        bus1.mem_ce_i = 1'b0; bus1.if_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_byte_store();
        int base;
        mem1[8'h80] = 32'h1122_3344;
        base = wr_count1;
        bus1.mem_ce_i = 1'b1; bus1.mem_we_i = 1'b1; bus1.mem_addr_i = 32'h200;
        bus1.mem_sel_i = 4'b0100; bus1.mem_data_i = 32'h00AB_0000;
        #1;
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL st_c0 got %b exp %b", ctl1, 8'hFF); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (ctl1 !== 8'hAB || bus1.sram_addr_o !== 20'h80 || bus1.sram_wdata_o !== 32'h00AB_0000) begin errors++; $display("FAIL st_c%0d ctl %b addr %h wd %h exp %b 80 00ab0000", c, ctl1, bus1.sram_addr_o, bus1.sram_wdata_o, 8'hAB); end
        end
        tick();
        checks++; if (ctl1 !== 8'h7F || bus1.mem_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_end ctl %b mem %h exp %b deadbeef", ctl1, bus1.mem_data_o, 8'h7F); end
        checks++; if (wr_word1 !== 32'h11AB_3344 || wr_count1 - base !== 2) begin errors++; $display("FAIL st_write word %h count %0d exp 11ab3344 2", wr_word1, wr_count1 - base); end
        $display("byte store: word %h writes %0d", wr_word1, wr_count1 - base);
        bus1.mem_ce_i = 1'b0; bus1.mem_we_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mem1[8'h40] = 32'hCAFE_F00D;
        bus1.mem_ce_i = 1'b1; bus1.mem_we_i = 1'b0; bus1.mem_addr_i = 32'h100; bus1.mem_sel_i = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (ctl1 !== 8'h7F || bus1.mem_data_o !== 32'd0) begin errors++; $display("FAIL rm_abort ctl %b mem %h exp %b 0", ctl1, bus1.mem_data_o, 8'h7F); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ctl1 !== 8'hFF) begin errors++; $display("FAIL rm_restart got %b exp %b", ctl1, 8'hFF); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++; if (ctl1 !== 8'h90 || bus1.sram_addr_o !== 20'h40) begin errors++; $display("FAIL rm_c%0d ctl %b addr %h exp %b 40", c, ctl1, bus1.sram_addr_o, 8'h90); end
        end
        tick();
        checks++; if (ctl1 !== 8'h7F || bus1.mem_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_end ctl %b mem %h exp %b cafef00d", ctl1, bus1.mem_data_o, 8'h7F); end
        $display("reset mid-access: mem %h", bus1.mem_data_o);
        bus1.mem_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        int high;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        words[0] = 32'hA000_0010; words[1] = 32'hB000_0021; words[2] = 32'hC000_0032;
        for (int k = 0; k < 3; k++) mem0[k] = words[k];
        bus0.if_ce_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus0.if_addr_i = addrs[k];
            #1;
            high = 0;
            while (bus0.stallreq_o === 1'b1 && high < 6) begin
                high++;
                tick();
            end
            checks++; if (high !== 2 || bus0.if_data_o !== words[k]) begin errors++; $display("FAIL b2b_%0d stall %0d data %h exp 2 %h", k, high, bus0.if_data_o, words[k]); end
            $display("b2b fetch %h: stall %0d data %h", addrs[k], high, bus0.if_data_o);
            tick();
        end
        bus0.if_ce_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_byte_store();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
